mem_port_arbiter: RTL and testbench

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/mem_port_arbiter.sv | 141 ++++++++++++++
 tb/tb_mem_port_arbiter.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Two-requester memory port arbiter: instruction fetch vs. load/store, load/store preferred,
// with a bounded starvation streak for fetch and a per-access timeout.
module mem_port_arbiter #(
    parameter int TIMEOUT    = 15,
    parameter int STARVE_MAX = 4
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_done,
    output logic        if_err,
    output logic [31:0] if_rdata,

    input  logic        ls_req,
    input  logic        ls_we,
    input  logic [31:0] ls_addr,
    input  logic [31:0] ls_wdata,
    input  logic [3:0]  ls_be,
    output logic        ls_done,
    output logic        ls_err,
    output logic [31:0] ls_rdata,

    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_be,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ready,

    output logic        busy
);

    localparam int WAIT_W = $clog2(TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);
    localparam logic [2:0] STREAK_MAX = 3'(STARVE_MAX);

    typedef enum logic [1:0] {
        IDLE,
        IF_BUSY,
        LS_BUSY,
        DONE
    } state_t;

    state_t            state;
    logic [2:0]        streak;
    logic [WAIT_W-1:0] wait_cnt;
    logic              ls_wins;

    // Load/store wins a tie unless fetch has already been passed over STARVE_MAX times.
    assign ls_wins = ls_req && !(if_req && (streak == STREAK_MAX));

    // The mem_* address/data/enable outputs are themselves the capture registers,
    // so requester inputs are ignored once a grant has been made.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            streak    <= '0;
            wait_cnt  <= '0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_be    <= '0;
            busy      <= 1'b0;
            if_done   <= 1'b0;
            if_err    <= 1'b0;
            if_rdata  <= '0;
            ls_done   <= 1'b0;
            ls_err    <= 1'b0;
            ls_rdata  <= '0;
        end else begin
            if_done <= 1'b0;
            ls_done <= 1'b0;

            case (state)
                IDLE: begin
                    if (ls_wins) begin
                        state     <= LS_BUSY;
                        mem_req   <= 1'b1;
                        busy      <= 1'b1;
                        wait_cnt  <= '0;
                        mem_addr  <= ls_addr;
                        mem_we    <= ls_we;
                        mem_wdata <= ls_wdata;
                        mem_be    <= ls_be;
                        if (!if_req) begin
                            streak <= '0;
                        end else if (streak != STREAK_MAX) begin
                            streak <= streak + 3'd1;
                        end
                    end else if (if_req) begin
                        state     <= IF_BUSY;
                        mem_req   <= 1'b1;
                        busy      <= 1'b1;
                        wait_cnt  <= '0;
                        mem_addr  <= if_addr;
                        mem_we    <= 1'b0;
                        mem_wdata <= '0;
                        mem_be    <= 4'hF;
                        streak    <= '0;
                    end
                end

                IF_BUSY, LS_BUSY: begin
                    // mem_ready wins over a timeout landing in the same cycle.
                    if (mem_ready || (wait_cnt == WAIT_LAST)) begin
                        state   <= DONE;
                        mem_req <= 1'b0;
                        mem_we  <= 1'b0;
                        mem_be  <= '0;
                        if (state == LS_BUSY) begin
                            ls_done  <= 1'b1;
                            ls_err   <= !mem_ready;
                            ls_rdata <= mem_ready ? mem_rdata : 32'h0;
                        end else begin
                            if_done  <= 1'b1;
                            if_err   <= !mem_ready;
                            if_rdata <= mem_ready ? mem_rdata : 32'h0;
                        end
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end

                DONE: begin
                    // Single settle cycle so a requester's stale req cannot be re-granted.
                    state <= IDLE;
                    busy  <= 1'b0;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter: fetch, tie-break, starvation limit,
// timeout versus late ready, and reset in the middle of a fetch.
module tb_mem_port_arbiter;

    logic        clk;
    logic        rst;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_done;
    logic        if_err;
    logic [31:0] if_rdata;
    logic        ls_req;
    logic        ls_we;
    logic [31:0] ls_addr;
    logic [31:0] ls_wdata;
    logic [3:0]  ls_be;
    logic        ls_done;
    logic        ls_err;
    logic [31:0] ls_rdata;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic [31:0] mem_rdata;
    logic        mem_ready;
    logic        busy;

    int compare_count = 0;
    int fail_count    = 0;

    mem_port_arbiter #(
        .TIMEOUT    (15),
        .STARVE_MAX (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_done   (if_done),
        .if_err    (if_err),
        .if_rdata  (if_rdata),
        .ls_req    (ls_req),
        .ls_we     (ls_we),
        .ls_addr   (ls_addr),
        .ls_wdata  (ls_wdata),
        .ls_be     (ls_be),
        .ls_done   (ls_done),
        .ls_err    (ls_err),
        .ls_rdata  (ls_rdata),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_be    (mem_be),
        .mem_rdata (mem_rdata),
        .mem_ready (mem_ready),
        .busy      (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        compare_count++;
        if (actual !== expected) begin
            fail_count++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic i_req, input logic [31:0] i_addr,
                                 input logic l_req, input logic l_we, input logic [31:0] l_addr,
                                 input logic [31:0] l_wdata, input logic [3:0] l_be);
        if_req   = i_req;
        if_addr  = i_addr;
        ls_req   = l_req;
        ls_we    = l_we;
        ls_addr  = l_addr;
        ls_wdata = l_wdata;
        ls_be    = l_be;
    endtask

    // Runs one load; mem_ready is raised only on busy cycle ready_cycle (0 = never).
    task automatic runLoad(input int ready_cycle, input logic [31:0] rdata_val,
                           output int busy_cycles, output logic err, output logic [31:0] rdata);
        bit seen = 0;
        busy_cycles = 0;
        err         = 1'bx;
        rdata       = 'x;
        mem_ready   = 1'b0;
        mem_rdata   = rdata_val;
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 32'h400, 32'h0, 4'hF);
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (ls_done) begin
                err       = ls_err;
                rdata     = ls_rdata;
                ls_req    = 1'b0;
                mem_ready = 1'b0;
                seen      = 1;
                break;
            end
            if (mem_req) begin
                busy_cycles++;
                mem_ready = (busy_cycles == ready_cycle);
            end
        end
        if (!seen) checkOutput("ls_done_bound", 32'h0, 32'h1);
        @(negedge clk);
    endtask

    initial begin
        int          n_grants;
        logic        prev_req;
        logic [31:0] grant_addr [10];
        int          busy_cycles;
        logic        err;
        logic [31:0] rdata;

        rst       = 1'b1;
        mem_ready = 1'b0;
        mem_rdata = 32'h0;
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);

        // Reset state
        @(negedge clk);
        @(negedge clk);
        checkOutput("rst_mem_req",  32'(mem_req),  32'h0);
        checkOutput("rst_busy",     32'(busy),     32'h0);
        checkOutput("rst_if_done",  32'(if_done),  32'h0);
        checkOutput("rst_ls_done",  32'(ls_done),  32'h0);
        checkOutput("rst_mem_addr", mem_addr,      32'h0);
        checkOutput("rst_if_rdata", if_rdata,      32'h0);

        // Fetch with mem_ready on the second busy cycle
        rst = 1'b0;
        applyStimulus(1'b1, 32'h100, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        @(negedge clk);
        checkOutput("if_mem_req",  32'(mem_req), 32'h1);
        checkOutput("if_mem_addr", mem_addr,     32'h100);
        checkOutput("if_mem_we",   32'(mem_we),  32'h0);
        checkOutput("if_mem_be",   32'(mem_be),  32'hF);
        checkOutput("if_busy",     32'(busy),    32'h1);
        @(negedge clk);
        checkOutput("if_no_early_done", 32'(if_done), 32'h0);
        mem_ready = 1'b1;
        mem_rdata = 32'hE3A01005;
        @(negedge clk);
        checkOutput("if_done",     32'(if_done), 32'h1);
        checkOutput("if_rdata",    if_rdata,     32'hE3A01005);
        checkOutput("if_err",      32'(if_err),  32'h0);
        checkOutput("if_done_busy", 32'(busy),   32'h1);
        checkOutput("if_done_req", 32'(mem_req), 32'h0);
        if_req    = 1'b0;
        mem_ready = 1'b0;
        @(negedge clk);
        checkOutput("if_done_pulse", 32'(if_done), 32'h0);
        checkOutput("if_idle_busy",  32'(busy),    32'h0);
        checkOutput("if_rdata_hold", if_rdata,     32'hE3A01005);

        // Simultaneous requests: store wins, inputs scrambled after grant, then fetch
        applyStimulus(1'b1, 32'h100, 1'b1, 1'b1, 32'h200, 32'h55, 4'h1);
        @(negedge clk);
        checkOutput("tie_mem_addr",  mem_addr,     32'h200);
        checkOutput("tie_mem_we",    32'(mem_we),  32'h1);
        checkOutput("tie_mem_be",    32'(mem_be),  32'h1);
        checkOutput("tie_mem_wdata", mem_wdata,    32'h55);
        ls_addr  = 32'hDEAD0000;
        ls_wdata = 32'hFFFFFFFF;
        ls_be    = 4'hE;
        ls_we    = 1'b0;
        @(negedge clk);
        checkOutput("hold_mem_addr",  mem_addr,    32'h200);
        checkOutput("hold_mem_wdata", mem_wdata,   32'h55);
        checkOutput("hold_mem_be",    32'(mem_be), 32'h1);
        mem_ready = 1'b1;
        mem_rdata = 32'h11112222;
        @(negedge clk);
        checkOutput("tie_ls_done",  32'(ls_done), 32'h1);
        checkOutput("tie_if_done",  32'(if_done), 32'h0);
        checkOutput("tie_ls_rdata", ls_rdata,     32'h11112222);
        ls_req    = 1'b0;
        mem_ready = 1'b0;
        @(negedge clk);
        checkOutput("tie_idle_req", 32'(mem_req), 32'h0);
        @(negedge clk);
        checkOutput("tie_if_grant", 32'(mem_req), 32'h1);
        checkOutput("tie_if_addr",  mem_addr,     32'h100);
        checkOutput("tie_if_be",    32'(mem_be),  32'hF);
        mem_ready = 1'b1;
        @(negedge clk);
        checkOutput("tie_if_done", 32'(if_done), 32'h1);
        if_req    = 1'b0;
        mem_ready = 1'b0;
        @(negedge clk);

        // Starvation: both requesters always pending in IDLE
        applyStimulus(1'b1, 32'h100, 1'b1, 1'b0, 32'h300, 32'h0, 4'hF);
        mem_ready = 1'b1;
        mem_rdata = 32'hCAFEF00D;
        n_grants  = 0;
        prev_req  = 1'b0;
        for (int c = 0; c < 100 && n_grants < 10; c++) begin
            @(negedge clk);
            if (mem_req && !prev_req) begin
                grant_addr[n_grants] = mem_addr;
                n_grants++;
            end
            prev_req = mem_req;
            ls_req   = !ls_done;
            if_req   = !if_done;
        end
        checkOutput("starve_grant_count", n_grants, 10);
        for (int i = 0; i < n_grants; i++) begin
            checkOutput($sformatf("starve_grant%0d", i), grant_addr[i],
                        (i % 5 == 4) ? 32'h100 : 32'h300);
        end
        ls_req = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (if_done) begin
                if_req = 1'b0;
                break;
            end
        end
        mem_ready = 1'b0;
        @(negedge clk);

        // Timeout with mem_ready never arriving
        runLoad(0, 32'h12121212, busy_cycles, err, rdata);
        checkOutput("to_busy_cycles", busy_cycles, 15);
        checkOutput("to_ls_err",      32'(err),    32'h1);
        checkOutput("to_ls_rdata",    rdata,       32'h0);
        checkOutput("to_err_hold",    32'(ls_err), 32'h1);

        // mem_ready exactly on the timeout cycle completes normally
        runLoad(15, 32'h600DF00D, busy_cycles, err, rdata);
        checkOutput("late_busy_cycles", busy_cycles, 15);
        checkOutput("late_ls_err",      32'(err),    32'h0);
        checkOutput("late_ls_rdata",    rdata,       32'h600DF00D);

        // Reset while a fetch is in flight
        applyStimulus(1'b1, 32'h180, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        @(negedge clk);
        checkOutput("rstmid_busy_before", 32'(mem_req), 32'h1);
        rst = 1'b1;
        @(negedge clk);
        rst    = 1'b0;
        if_req = 1'b0;
        checkOutput("rstmid_mem_req",  32'(mem_req), 32'h0);
        checkOutput("rstmid_busy",     32'(busy),    32'h0);
        checkOutput("rstmid_if_done",  32'(if_done), 32'h0);
        checkOutput("rstmid_ls_rdata", ls_rdata,     32'h0);
        @(negedge clk);
        checkOutput("rstmid_no_done", 32'(if_done), 32'h0);
        applyStimulus(1'b1, 32'h140, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        @(negedge clk);
        checkOutput("rstmid_new_req",  32'(mem_req), 32'h1);
        checkOutput("rstmid_new_addr", mem_addr,     32'h140);
        mem_ready = 1'b1;
        mem_rdata = 32'h0000A5A5;
        @(negedge clk);
        checkOutput("rstmid_new_done",  32'(if_done), 32'h1);
        checkOutput("rstmid_new_rdata", if_rdata,     32'h0000A5A5);
        checkOutput("rstmid_new_err",   32'(if_err),  32'h0);
        if_req    = 1'b0;
        mem_ready = 1'b0;
        @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compare_count, fail_count);
        $finish;
    end

endmodule
